// File: rtl/ps2_pkg.sv
// Shared PS/2 key-filter definitions: prefix bytes, accepted scan-code table,
// FSM state encoding and the queued event word layout {ext, brk, code}.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int         EVT_W   = 10;
    localparam int         KEY_TABLE_N = 16;

    localparam logic [KEY_TABLE_N-1:0][7:0] KEY_TABLE = {
        8'h2D, 8'h5A, 8'h34, 8'h4D, 8'h1C, 8'h33, 8'h45, 8'h46,
        8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXT  = 2'd1,
        ST_BRK  = 2'd2,
        ST_EMIT = 2'd3
    } ps2_state_e;

    function automatic logic in_key_table(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < KEY_TABLE_N; i++) begin
            hit = hit | (KEY_TABLE[i] == code);
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous show-ahead FIFO for key events with a sticky overflow flag;
// a simultaneous push and pop always completes, even when full.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = EVT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   ovf_clr,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A refused push is a drop; a clear in the same cycle loses to it.
        ovf_d = (ovf_q && !ovf_clr) || (push && !do_push);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rdata    = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/ps2_key_filter.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events and queues them.
// Define PS2_MAKE_EVENTS_EN to also queue key presses; by default only releases.
module ps2_key_filter
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ACCEPT_ALL = 0
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        tick,
    input  logic [7:0]                  din,
    input  logic                        rd_en,
    input  logic                        ovf_clr,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_brk,
    output logic                        key_empty,
    output logic                        key_full,
    output logic [$clog2(FIFO_DEPTH):0] key_count,
    output logic                        rx_tick,
    output logic                        overflow
);

`ifdef PS2_MAKE_EVENTS_EN
    localparam bit MAKE_EN = 1'b1;
`else
    localparam bit MAKE_EN = 1'b0;
`endif

    ps2_state_e       state_q;
    ps2_state_e       dec_state;
    logic             ext_q;
    logic             rx_tick_q;
    logic [EVT_W-1:0] evt_q;
    logic [EVT_W-1:0] head;
    logic             accepted;

    // EMIT is a one-cycle pass-through, so a tick there decodes like IDLE.
    always_comb begin
        accepted  = (ACCEPT_ALL != 0) ? ((din != PS2_EXT) && (din != PS2_BRK))
                                      : in_key_table(din);
        dec_state = (state_q == ST_EMIT) ? ST_IDLE : state_q;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ext_q     <= 1'b0;
            rx_tick_q <= 1'b0;
            evt_q     <= '0;
        end else begin
            rx_tick_q <= 1'b0;
            if (state_q == ST_EMIT) begin
                state_q <= ST_IDLE;
            end
            if (tick) begin
                case (dec_state)
                    ST_IDLE: begin
                        ext_q <= 1'b0;
                        if (din == PS2_EXT) begin
                            state_q <= ST_EXT;
                        end else if (din == PS2_BRK) begin
                            state_q <= ST_BRK;
                        end else if (MAKE_EN && accepted) begin
                            state_q   <= ST_EMIT;
                            rx_tick_q <= 1'b1;
                            evt_q     <= {1'b0, 1'b0, din};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_EXT: begin
                        if (din == PS2_BRK) begin
                            state_q <= ST_BRK;
                            ext_q   <= 1'b1;
                        end else if (MAKE_EN && accepted) begin
                            state_q   <= ST_EMIT;
                            rx_tick_q <= 1'b1;
                            evt_q     <= {1'b1, 1'b0, din};
                            ext_q     <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            ext_q   <= 1'b0;
                        end
                    end
                    ST_BRK: begin
                        if (din == PS2_BRK) begin
                            state_q <= ST_BRK;
                        end else if (accepted) begin
                            state_q   <= ST_EMIT;
                            rx_tick_q <= 1'b1;
                            evt_q     <= {ext_q, 1'b1, din};
                            ext_q     <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            ext_q   <= 1'b0;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (reset),
        .push     (rx_tick_q),
        .wdata    (evt_q),
        .pop      (rd_en),
        .ovf_clr  (ovf_clr),
        .rdata    (head),
        .empty    (key_empty),
        .full     (key_full),
        .count    (key_count),
        .overflow (overflow)
    );

    assign {key_ext, key_brk, key_code} = head;
    assign rx_tick = rx_tick_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Bench for ps2_key_filter: directed protocol cases, then random byte streams
// compared against a prefix-flag parser and an event queue.
module tb_ps2_key_filter;

    localparam int DEPTH = 4;
`ifdef PS2_MAKE_EVENTS_EN
    localparam bit MAKE_EN = 1'b1;
`else
    localparam bit MAKE_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;

    logic [7:0] key_code;
    logic       key_ext, key_brk, key_empty, key_full, rx_tick, overflow;
    logic [2:0] key_count;

    logic [7:0] a_code;
    logic       a_ext, a_brk, a_empty, a_full, a_rx, a_ovf;
    logic [2:0] a_count;

    always #5 CLK = ~CLK;

    ps2_key_filter #(.FIFO_DEPTH(DEPTH), .ACCEPT_ALL(0)) dut (
        .CLK(CLK), .reset(reset), .tick(tick), .din(din), .rd_en(rd_en),
        .ovf_clr(ovf_clr), .key_code(key_code), .key_ext(key_ext),
        .key_brk(key_brk), .key_empty(key_empty), .key_full(key_full),
        .key_count(key_count), .rx_tick(rx_tick), .overflow(overflow)
    );

    ps2_key_filter #(.FIFO_DEPTH(DEPTH), .ACCEPT_ALL(1)) dut_all (
        .CLK(CLK), .reset(reset), .tick(tick), .din(din), .rd_en(rd_en),
        .ovf_clr(ovf_clr), .key_code(a_code), .key_ext(a_ext),
        .key_brk(a_brk), .key_empty(a_empty), .key_full(a_full),
        .key_count(a_count), .rx_tick(a_rx), .overflow(a_ovf)
    );

    logic [7:0] tb_table [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                  8'h46, 8'h45, 8'h33, 8'h1C, 8'h4D, 8'h34, 8'h5A, 8'h2D};

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: prefix flags seen so far, queue of {ext,brk,code}, one pending push.
    logic       m_e0, m_f0, m_ovf, m_rx, pend_vld;
    logic [9:0] pend;
    logic [9:0] q[$];

    function automatic logic tb_acc(input logic [7:0] b);
        for (int i = 0; i < 16; i++) begin
            if (tb_table[i] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("rx_tick", {31'd0, rx_tick}, {31'd0, m_rx});
        chk("key_empty", {31'd0, key_empty}, {31'd0, q.size() == 0});
        chk("key_full", {31'd0, key_full}, {31'd0, q.size() == DEPTH});
        chk("key_count", {29'd0, key_count}, q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() > 0) chk("head", {22'd0, key_ext, key_brk, key_code}, {22'd0, q[0]});
    endtask

    task automatic cycle(input logic t, input logic [7:0] b, input logic rd, input logic clr);
        logic       drop, ev_vld;
        logic [9:0] ev;
        tick = t; din = b; rd_en = rd; ovf_clr = clr;
        drop = 1'b0;
        if (rd && q.size() > 0) void'(q.pop_front());
        if (pend_vld) begin
            if (q.size() < DEPTH) q.push_back(pend);
            else drop = 1'b1;
        end
        m_ovf = (m_ovf && !clr) || drop;
        ev_vld = 1'b0;
        ev = '0;
        if (t) begin
            if (b == 8'hF0) begin
                m_f0 = 1'b1;
            end else if (b == 8'hE0 && !m_e0 && !m_f0) begin
                m_e0 = 1'b1;
            end else begin
                if (tb_acc(b) && (m_f0 || MAKE_EN)) begin
                    ev_vld = 1'b1;
                    ev = {m_e0, m_f0, b};
                end
                m_e0 = 1'b0;
                m_f0 = 1'b0;
            end
        end
        m_rx = ev_vld;
        pend_vld = ev_vld;
        pend = ev;
        @(posedge CLK);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        tick = 1'b0; din = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_rx_tick", {31'd0, rx_tick}, 0);
        chk("rst_empty", {31'd0, key_empty}, 1);
        chk("rst_full", {31'd0, key_full}, 0);
        chk("rst_count", {29'd0, key_count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_head", {22'd0, key_ext, key_brk, key_code}, 0);
        chk("rst_all_empty", {31'd0, a_empty}, 1);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        m_e0 = 1'b0; m_f0 = 1'b0; m_ovf = 1'b0; m_rx = 1'b0; pend_vld = 1'b0; pend = '0;
        q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         r;

        do_reset();

        // Plain release: F0,16
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h16, 0, 0);
        chk("rx_after_16", {31'd0, rx_tick}, 1);
        cycle(0, 8'h00, 0, 0);
        chk("head_16", {22'd0, key_ext, key_brk, key_code}, 10'h116);
        chk("count_16", {29'd0, key_count}, 1);

        // Extended release, and repeated F0
        do_reset();
        cycle(1, 8'hE0, 0, 0);
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h5A, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("head_e0_5a", {22'd0, key_ext, key_brk, key_code}, 10'h35A);
        do_reset();
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h33, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("count_f0f0_33", {29'd0, key_count}, 1);
        chk("head_f0f0_33", {22'd0, key_ext, key_brk, key_code}, 10'h133);

        // Non-table code: only the accept-all instance queues it
        do_reset();
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h29, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("empty_29", {31'd0, key_empty}, 1);
        chk("all_empty_29", {31'd0, a_empty}, 0);
        chk("all_head_29", {22'd0, a_ext, a_brk, a_code}, 10'h129);

        // Overflow with back-to-back ticks, then push+pop while full
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'hF0, 0, 0);
            cycle(1, tb_table[i], 0, 0);
        end
        cycle(0, 8'h00, 0, 0);
        chk("full_5", {31'd0, key_full}, 1);
        chk("ovf_5", {31'd0, overflow}, 1);
        chk("count_5", {29'd0, key_count}, 4);
        chk("head_5", {22'd0, key_ext, key_brk, key_code}, 10'h116);
        cycle(1, 8'hF0, 0, 0);
        cycle(1, 8'h36, 0, 0);
        cycle(0, 8'h00, 1, 0);
        chk("count_pushpop", {29'd0, key_count}, 4);
        chk("head_pushpop", {22'd0, key_ext, key_brk, key_code}, 10'h11E);
        cycle(0, 8'h00, 0, 1);
        chk("ovf_cleared", {31'd0, overflow}, 0);

        // Make code alone
        do_reset();
        cycle(1, 8'h1C, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        if (MAKE_EN) chk("make_1c", {22'd0, key_ext, key_brk, key_code}, 10'h01C);
        else         chk("make_1c_empty", {31'd0, key_empty}, 1);

        // Reset between F0 and the code byte
        do_reset();
        cycle(1, 8'hF0, 0, 0);
        do_reset();
        cycle(1, 8'h16, 0, 0);
        cycle(0, 8'h00, 0, 0);
        if (!MAKE_EN) chk("midreset_empty", {31'd0, key_empty}, 1);
        chk("midreset_ovf", {31'd0, overflow}, 0);

        // Random byte streams
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hF0;
            else if (r < 3) b = 8'hE0;
            else if (r < 7) b = tb_table[$urandom_range(0, 15)];
            else            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 9) < 6), b,
                      1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
